// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources.
// Optional busy scoreboard for decode stalls, enabled by defining WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int AW      = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hold,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*AW-1:0]   req_rd,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic                    rf_reg_write,
  output logic [AW-1:0]           rf_rd,
  output logic [XLEN-1:0]         rf_datain,
  input  logic                    sb_set_valid,
  input  logic [AW-1:0]           sb_set_rd,
  input  logic [AW-1:0]           sb_rs1,
  input  logic [AW-1:0]           sb_rs2,
  output logic                    sb_busy_rs1,
  output logic                    sb_busy_rs2
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rf_reg_write_q, rf_reg_write_d;
  logic [AW-1:0]   rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_datain_q, rf_datain_d;

  logic            grant_vld;
  logic [PW-1:0]   grant_idx;
  logic [AW-1:0]   grant_rd;
  logic [XLEN-1:0] grant_data;

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    logic [PW:0] idx;
    idx       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    if (!reset && !hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = {1'b0, ptr_q} + (PW+1)'(k);
        if (idx >= (PW+1)'(NUM_REQ)) idx = idx - (PW+1)'(NUM_REQ);
        if (!grant_vld && req_valid[idx[PW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = idx[PW-1:0];
        end
      end
      if (grant_vld) req_ready[grant_idx] = 1'b1;
    end
  end

  assign grant_rd   = req_rd[grant_idx*AW +: AW];
  assign grant_data = req_data[grant_idx*XLEN +: XLEN];

  always_comb begin
    ptr_d          = ptr_q;
    rf_reg_write_d = 1'b0;
    rf_rd_d        = rf_rd_q;
    rf_datain_d    = rf_datain_q;
    if (grant_vld) begin
      ptr_d          = (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + PW'(1);
      // x0 transfers are consumed but never strobe the register file.
      rf_reg_write_d = (grant_rd != '0);
      rf_rd_d        = grant_rd;
      rf_datain_d    = grant_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q          <= '0;
      rf_reg_write_q <= 1'b0;
      rf_rd_q        <= '0;
      rf_datain_q    <= '0;
    end else begin
      ptr_q          <= ptr_d;
      rf_reg_write_q <= rf_reg_write_d;
      rf_rd_q        <= rf_rd_d;
      rf_datain_q    <= rf_datain_d;
    end
  end

  assign rf_reg_write = rf_reg_write_q;
  assign rf_rd        = rf_rd_q;
  assign rf_datain    = rf_datain_q;

`ifdef WB_SCOREBOARD_EN
  localparam int NREG = 1 << AW;
  logic [NREG-1:0] busy_q, busy_d;

  // Clear first so that a same-edge set of the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_reg_write_q) busy_d[rf_rd_q] = 1'b0;
    if (sb_set_valid && sb_set_rd != '0) busy_d[sb_set_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign sb_busy_rs1 = busy_q[sb_rs1];
  assign sb_busy_rs2 = busy_q[sb_rs2];
`else
  logic unused_sb;
  assign unused_sb   = ^{sb_set_valid, sb_set_rd, sb_rs1, sb_rs2};
  assign sb_busy_rs1 = 1'b0;
  assign sb_busy_rs2 = 1'b0;
`endif

endmodule
